axis_packet_demux: RTL
======================

// Module: axis_packet_demux
// PURPOSE
//  Inverse of the N:1 AXI-Stream packet mux. Takes one AXI-Stream of FMPS/CC packets (header word + data words),
//  decodes the header index field and steers each whole packet to one of NUM_DESTS master ports.
//  Packets with a bad magic or an out-of-range index are dropped and counted. Single clock domain.
// PARAMETERS
//  DATA_WIDTH      32     tdata width
//  USER_WIDTH      1      tuser width, carried through unchanged
//  NUM_DESTS       4      number of master ports (2..16)
//  MAGIC_WIDTH     16     header magic width
//  MAGIC_START_BIT 16     LSB of the magic in the header word
//  INDEX_WIDTH     5      header index width
//  INDEX_START_BIT 10     LSB of the index in the header word
//  INDEX_PER_DEST  4      consecutive indices per port (power of 2); dest = index / INDEX_PER_DEST
//  EXPECTED_MAGIC  16'hB6CF  required header magic
// PORTS
//  clk          in   1                     single clock
//  arst_n       in   1                     asynchronous reset, active low
//  s_tvalid     in   1                     slave valid
//  s_tready     out  1                     slave ready
//  s_tlast      in   1                     slave last
//  s_tdata      in   DATA_WIDTH            slave data
//  s_tuser      in   USER_WIDTH            slave user
//  m_tvalid     out  NUM_DESTS             per-port valid
//  m_tready     in   NUM_DESTS             per-port ready
//  m_tlast      out  1                     shared last (qualified by m_tvalid[d])
//  m_tdata      out  DATA_WIDTH            shared data
//  m_tuser      out  USER_WIDTH            shared user
//  dropCount    out  16                    dropped-packet count, saturating
//  pktCount     out  16*NUM_DESTS          per-port forwarded-packet count (stats option)
// BEHAVIOUR
//  - Reset (arst_n=0, async): m_tvalid=0, m_tdata/m_tuser/m_tlast=0, dropCount=0, pktCount=0, state=IDLE.
//    s_tready=0 while in reset.
//  - Output stage: one register shared by all ports; m_tvalid is one-hot or zero. Latency is 1 cycle from the
//    s_ handshake to m_tvalid[d]. Register loads when empty or m_tready[sel] is high (full throughput).
//  - FSM:
//    - IDLE: the next accepted word is the header. hdrOK = magic==EXPECTED_MAGIC && dest<NUM_DESTS.
//      - hdrOK: latch sel=dest and forward the header. Next state FWD, or stay IDLE if s_tlast.
//      - otherwise: do not forward the word. Next state DROP, or stay IDLE with dropCount+1 if s_tlast.
//    - FWD: forward each word to port sel. On s_tlast go to IDLE and pktCount[sel]+1.
//    - DROP: s_tready=1 and swallow words. On s_tlast go to IDLE and dropCount+1.
//  - s_tready:
//    - IDLE: register empty, or m_tready of the port currently held.
//    - FWD: !m_tvalid[sel] || m_tready[sel].
//    - DROP: 1.
//  - Header decode is combinational on s_tdata. A new packet's header may load in the same cycle the previous
//    tlast drains (no bubble).
//  - Counters saturate at 16'hFFFF. No wrap.
//  - m_tvalid never deasserts until accepted. tdata/tlast/tuser stay stable while valid and not ready.
//  - Mid-packet reset: all state cleared. The first word after reset is treated as a header.
// CONFIGURATION
//  AXIS_DEMUX_STATS_EN
//  - Defined: pktCount per-port counters are implemented as described.
//  - Undefined: pktCount tied to 0, no counter logic. dropCount is always present.
// TESTING
//  1. Header 0xB6CF_0C00 (index 3), 2 words, all m_tready=1 -> port 0 only; m_tvalid[0] 1 cycle after each
//     accept; m_tlast on word 2.
//  2. Four packets, index 0/4/8/12 -> ports 0/1/2/3 in order; pktCount = 1 each (STATS_EN); dropCount = 0.
//  3. Magic 0xDEAD, 2 words -> no m_tvalid; s_tready held 1; dropCount = 1.
//  4. Index 16 with NUM_DESTS=4 -> dropped; dropCount increments; next valid packet routed correctly.
//  5. m_tready[1] random 50% during a 4-word packet to port 1 -> all 4 words in order; other ports never valid;
//     data stable while stalled.
//  6. arst_n low mid-packet -> outputs 0 immediately; after release, a new header routes correctly and the
//     stale tail is not emitted.

Source files
------------

// File: rtl/axis_packet_demux.sv
// AXI-Stream packet demux: decodes the header index of each packet and steers the whole packet to one port.
// Optional per-port forwarded-packet counters are enabled by defining AXIS_DEMUX_STATS_EN.
module axis_packet_demux #(
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int NUM_DESTS       = 4,
  parameter int MAGIC_WIDTH     = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH     = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int INDEX_PER_DEST  = 4,
  parameter logic [MAGIC_WIDTH-1:0] EXPECTED_MAGIC = 16'hB6CF
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [USER_WIDTH-1:0]   s_tuser,
  output logic [NUM_DESTS-1:0]    m_tvalid,
  input  logic [NUM_DESTS-1:0]    m_tready,
  output logic                    m_tlast,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic [15:0]             dropCount,
  output logic [16*NUM_DESTS-1:0] pktCount
);

  localparam int IDX_SHIFT = $clog2(INDEX_PER_DEST);
  localparam int SEL_WIDTH = $clog2(NUM_DESTS);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                 state_reg, state_next;
  logic [SEL_WIDTH-1:0]   sel_reg, sel_next;
  logic                   run_reg;
  logic [NUM_DESTS-1:0]   valid_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic [USER_WIDTH-1:0]  user_reg;
  logic                   last_reg;
  logic [15:0]            drop_reg;

  logic [MAGIC_WIDTH-1:0] hdr_magic;
  logic [INDEX_WIDTH-1:0] hdr_index;
  logic [INDEX_WIDTH-1:0] hdr_dest;
  logic [SEL_WIDTH-1:0]   hdr_sel;
  logic                   hdr_ok;
  logic                   can_load;
  logic                   ready;
  logic                   accept;
  logic                   fwd;
  logic [SEL_WIDTH-1:0]   fwd_sel;
  logic                   drop_inc;
  logic                   pkt_inc;
  logic [SEL_WIDTH-1:0]   pkt_sel;

  assign hdr_magic = s_tdata[MAGIC_START_BIT +: MAGIC_WIDTH];
  assign hdr_index = s_tdata[INDEX_START_BIT +: INDEX_WIDTH];
  assign hdr_dest  = hdr_index >> IDX_SHIFT;
  assign hdr_sel   = SEL_WIDTH'(hdr_dest);
  assign hdr_ok    = (hdr_magic == EXPECTED_MAGIC) && (int'(hdr_dest) < NUM_DESTS);

  // The shared output register can take a new word when empty or when its held word leaves this cycle.
  assign can_load = !(|valid_reg) || (|(valid_reg & m_tready));
  assign s_tready = ready & run_reg;
  assign accept   = s_tvalid & s_tready;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ready      = 1'b0;
    fwd        = 1'b0;
    fwd_sel    = sel_reg;
    drop_inc   = 1'b0;
    pkt_inc    = 1'b0;
    pkt_sel    = sel_reg;
    case (state_reg)
      IDLE: begin
        ready = can_load;
        if (accept) begin
          if (hdr_ok) begin
            fwd      = 1'b1;
            fwd_sel  = hdr_sel;
            sel_next = hdr_sel;
            if (s_tlast) begin
              pkt_inc = 1'b1;
              pkt_sel = hdr_sel;
            end else begin
              state_next = FWD;
            end
          end else if (s_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_next = DROP;
          end
        end
      end
      FWD: begin
        ready = can_load;
        if (accept) begin
          fwd = 1'b1;
          if (s_tlast) begin
            pkt_inc    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        ready = 1'b1;
        if (accept && s_tlast) begin
          drop_inc   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      run_reg   <= 1'b1;
    end
  end

  // Data fields are only rewritten on a load, so they hold steady while a stalled word waits.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_reg <= '0;
      data_reg  <= '0;
      user_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (fwd) begin
      valid_reg <= NUM_DESTS'(1) << fwd_sel;
      data_reg  <= s_tdata;
      user_reg  <= s_tuser;
      last_reg  <= s_tlast;
    end else if (|(valid_reg & m_tready)) begin
      valid_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      drop_reg <= '0;
    end else if (drop_inc && drop_reg != 16'hFFFF) begin
      drop_reg <= drop_reg + 16'd1;
    end
  end

  assign m_tvalid  = valid_reg;
  assign m_tdata   = data_reg;
  assign m_tuser   = user_reg;
  assign m_tlast   = last_reg;
  assign dropCount = drop_reg;

`ifdef AXIS_DEMUX_STATS_EN
  generate
    for (genvar gi = 0; gi < NUM_DESTS; gi++) begin : g_pkt_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cnt_reg <= '0;
        end else if (pkt_inc && pkt_sel == SEL_WIDTH'(gi) && cnt_reg != 16'hFFFF) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign pktCount[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`else
  logic stats_unused;
  assign stats_unused = pkt_inc ^ (^pkt_sel);
  assign pktCount     = '0;
`endif

endmodule
